// File: rtl/clock_divider_bank.sv
// Bank of CHANNELS programmable clock dividers, optionally cascaded, each producing a
// one-cycle tick and a 50%-duty square wave. Divisor updates are handshaked and applied at wrap.
module clock_divider_bank #(
    parameter int CHANNELS    = 3,
    parameter int CNT_WIDTH   = 32,
    parameter int DEFAULT_DIV = 250000,
    parameter int CASCADE     = 1,
    parameter int SEL_WIDTH   = 3
) (
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [SEL_WIDTH-1:0] cfg_chan,
    input  logic [CNT_WIDTH-1:0] cfg_div,
    output logic [CHANNELS-1:0]  tick_out,
    output logic [CHANNELS-1:0]  clock_out,
    output logic [CHANNELS-1:0]  busy
);

    localparam logic [CNT_WIDTH-1:0] DEF_DIV = CNT_WIDTH'(DEFAULT_DIV);

    logic xfer;

    // Out-of-range channels always look ready so their writes are swallowed.
    always_comb begin
        cfg_ready = 1'b1;
        for (int k = 0; k < CHANNELS; k++) begin
            if (cfg_chan == SEL_WIDTH'(k)) cfg_ready = ~busy[k];
        end
    end

    assign xfer = cfg_valid & cfg_ready;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        logic                 en;
        logic                 wrap;
        logic                 load;
        logic                 tick_r;
        logic                 clk_r;
        logic                 pend_r;
        logic [CNT_WIDTH-1:0] cnt_r;
        logic [CNT_WIDTH-1:0] div_r;
        logic [CNT_WIDTH-1:0] nxt_r;

        if (k == 0 || CASCADE == 0) begin : g_en_direct
            assign en = run;
        end else begin : g_en_cascade
            assign en = run & tick_out[k-1];
        end

        assign wrap = en & (cnt_r == div_r);
        assign load = xfer & (cfg_chan == SEL_WIDTH'(k));

        always_ff @(posedge clock_in) begin
            if (reset) begin
                tick_r <= 1'b0;
                clk_r  <= 1'b0;
                pend_r <= 1'b0;
                cnt_r  <= '0;
                div_r  <= DEF_DIV;
                nxt_r  <= DEF_DIV;
            end else begin
                tick_r <= wrap;
                if (wrap) clk_r <= ~clk_r;

                if (wrap) begin
                    cnt_r <= '0;
                    if (pend_r) begin
                        div_r  <= nxt_r;
                        pend_r <= 1'b0;
                    end
                end else if (en) begin
                    cnt_r <= cnt_r + 1'b1;
                end

                // A transfer only happens while not pending, so it never collides with the apply above.
                if (load) begin
                    if (run) begin
                        nxt_r  <= cfg_div;
                        pend_r <= 1'b1;
                    end else begin
                        div_r <= cfg_div;
                        cnt_r <= '0;
                    end
                end
            end
        end

        assign tick_out[k]  = tick_r;
        assign clock_out[k] = clk_r;
        assign busy[k]      = pend_r;
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Bench for clock_divider_bank: two instances (independent D=3, cascaded D=1) driven with shared
// stimulus, checked against a per-cycle behavioural model, a vector table and directed sequences.
module tb_clock_divider_bank;

    logic       clk = 1'b0;
    logic       reset, run, cfg_valid;
    logic [2:0] cfg_chan;
    logic [7:0] cfg_div;
    logic       rdy  [2];
    logic [2:0] tick [2];
    logic [2:0] clko [2];
    logic [2:0] busy [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clock_divider_bank #(.CHANNELS(3), .CNT_WIDTH(8), .DEFAULT_DIV(3), .CASCADE(0), .SEL_WIDTH(3)) u0 (
        .clock_in(clk), .reset(reset), .run(run), .cfg_valid(cfg_valid), .cfg_ready(rdy[0]),
        .cfg_chan(cfg_chan), .cfg_div(cfg_div), .tick_out(tick[0]), .clock_out(clko[0]), .busy(busy[0]));

    clock_divider_bank #(.CHANNELS(3), .CNT_WIDTH(8), .DEFAULT_DIV(1), .CASCADE(1), .SEL_WIDTH(3)) u1 (
        .clock_in(clk), .reset(reset), .run(run), .cfg_valid(cfg_valid), .cfg_ready(rdy[1]),
        .cfg_chan(cfg_chan), .cfg_div(cfg_div), .tick_out(tick[1]), .clock_out(clko[1]), .busy(busy[1]));

    // Model: per channel, the number of enable events since the last restart and the active period.
    int m_ev [2][3];
    int m_dv [2][3];
    int m_nx [2][3];
    bit m_pd [2][3];
    bit m_tk [2][3];
    bit m_co [2][3];
    int DEFV [2] = '{3, 1};
    bit CASC [2] = '{1'b0, 1'b1};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic model_edge();
        int ch;
        bit x;
        bit otk [3];
        bit en;
        bit wrap;
        ch = int'(cfg_chan);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                for (int k = 0; k < 3; k++) begin
                    m_ev[i][k] = 0; m_dv[i][k] = DEFV[i]; m_nx[i][k] = DEFV[i];
                    m_pd[i][k] = 0; m_tk[i][k] = 0; m_co[i][k] = 0;
                end
            end else begin
                x = cfg_valid;
                if (ch < 3) begin
                    if (m_pd[i][ch]) x = 0;
                end
                for (int k = 0; k < 3; k++) otk[k] = m_tk[i][k];
                for (int k = 0; k < 3; k++) begin
                    en = run && (k == 0 || !CASC[i] || otk[k-1]);
                    wrap = en && (m_ev[i][k] == m_dv[i][k]);
                    m_tk[i][k] = wrap;
                    if (wrap) m_co[i][k] = !m_co[i][k];
                    if (wrap) begin
                        m_ev[i][k] = 0;
                        if (m_pd[i][k]) begin m_dv[i][k] = m_nx[i][k]; m_pd[i][k] = 0; end
                    end else if (en) begin
                        m_ev[i][k] = m_ev[i][k] + 1;
                    end
                    if (x && ch == k) begin
                        if (run) begin m_nx[i][k] = int'(cfg_div); m_pd[i][k] = 1; end
                        else begin m_dv[i][k] = int'(cfg_div); m_ev[i][k] = 0; end
                    end
                end
            end
        end
    endtask

    task automatic compare();
        logic [2:0] et, ec, eb;
        logic er;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) begin
                et[k] = m_tk[i][k]; ec[k] = m_co[i][k]; eb[k] = m_pd[i][k];
            end
            er = 1'b1;
            if (cfg_chan < 3) er = !m_pd[i][cfg_chan];
            chk($sformatf("u%0d tick", i), 32'(tick[i]), 32'(et));
            chk($sformatf("u%0d clock", i), 32'(clko[i]), 32'(ec));
            chk($sformatf("u%0d busy", i), 32'(busy[i]), 32'(eb));
            chk($sformatf("u%0d ready", i), 32'(rdy[i]), 32'(er));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    // Steps until tick_out[k] of instance i is high; n = cycles taken.
    task automatic wait_tick(input int i, input int k, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick[i][k] && n < 400);
        if (!tick[i][k]) begin
            checks++;
            failures++;
            $display("FAIL wait_tick u%0d ch%0d actual=timeout required=tick", i, k);
        end
    endtask

    typedef struct {
        logic       t0;
        logic       c0;
        logic [2:0] t1;
    } vec_t;

    vec_t vt [10];
    int n;
    logic [2:0] held_clk;
    int bad;

    initial begin
        // After reset: u0 ch0 (D=3) ticks every 4, clock period 8; u1 cascade (D=1) halves each stage.
        vt[0] = '{1'b0, 1'b0, 3'b000};
        vt[1] = '{1'b0, 1'b0, 3'b001};
        vt[2] = '{1'b0, 1'b0, 3'b000};
        vt[3] = '{1'b1, 1'b1, 3'b001};
        vt[4] = '{1'b0, 1'b1, 3'b010};
        vt[5] = '{1'b0, 1'b1, 3'b001};
        vt[6] = '{1'b0, 1'b1, 3'b000};
        vt[7] = '{1'b1, 1'b0, 3'b001};
        vt[8] = '{1'b0, 1'b0, 3'b010};
        vt[9] = '{1'b0, 1'b0, 3'b101};

        reset = 1; run = 1; cfg_valid = 0; cfg_chan = 0; cfg_div = 0;
        step();
        chk("reset tick u0", 32'(tick[0]), 0);
        chk("reset clock u1", 32'(clko[1]), 0);
        reset = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("vec%0d u0 tick0", c), 32'(tick[0][0]), 32'(vt[c].t0));
            chk($sformatf("vec%0d u0 clock0", c), 32'(clko[0][0]), 32'(vt[c].c0));
            chk($sformatf("vec%0d u1 tick", c), 32'(tick[1]), 32'(vt[c].t1));
        end
        wait_tick(1, 2, n);
        wait_tick(1, 2, n);
        chk("cascade tick2 period", n, 8);

        // D=9 on ch0, then a write of 2 at cnt=4 which pends until the wrap.
        run = 0; cfg_valid = 1; cfg_chan = 0; cfg_div = 9;
        step();
        cfg_valid = 0;
        step();
        run = 1;
        repeat (4) step();
        cfg_valid = 1; cfg_div = 2;
        #1;
        chk("ready before write", 32'(rdy[0]), 1);
        step();
        cfg_div = 7;
        step();
        chk("second write stalls", 32'(rdy[0]), 0);
        chk("busy while pending", 32'(busy[0][0]), 1);
        cfg_valid = 0;
        wait_tick(0, 0, n);
        chk("first wrap at old D", n, 4);
        chk("busy clears at wrap", 32'(busy[0][0]), 0);
        wait_tick(0, 0, n);
        chk("new period a", n, 3);
        wait_tick(0, 0, n);
        chk("new period b", n, 3);

        // Write landing exactly in the wrap cycle: one more old period, then new.
        run = 0; cfg_valid = 1; cfg_div = 9;
        step();
        cfg_valid = 0; run = 1;
        repeat (9) step();
        cfg_valid = 1; cfg_div = 2;
        step();
        chk("tick in wrap cycle", 32'(tick[0][0]), 1);
        cfg_valid = 0;
        wait_tick(0, 0, n);
        chk("old period after wrap write", n, 10);
        wait_tick(0, 0, n);
        chk("new period after wrap write", n, 3);

        // Pause mid-count for 20 cycles.
        step();
        run = 0;
        step();
        held_clk = clko[0];
        bad = 0;
        repeat (20) begin
            step();
            if (tick[0] != 0 || clko[0] != held_clk) bad++;
        end
        chk("paused outputs frozen", bad, 0);
        run = 1;
        wait_tick(0, 0, n);
        chk("resume from held count", n, 2);

        // Reset while ch1 has a pending update.
        cfg_valid = 1; cfg_chan = 1; cfg_div = 6;
        step();
        cfg_valid = 0;
        chk("busy1 before reset", 32'(busy[0][1]), 1);
        reset = 1;
        step();
        chk("reset clears busy", 32'(busy[0]), 0);
        chk("reset clears tick", 32'(tick[0]), 0);
        chk("reset clears clock", 32'(clko[0]), 0);
        reset = 0;
        wait_tick(0, 1, n);
        chk("default D after reset a", n, 4);
        wait_tick(0, 1, n);
        chk("default D after reset b", n, 4);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(499) == 0);
            run = ($urandom_range(7) != 0);
            cfg_valid = ($urandom_range(5) == 0);
            cfg_chan = 3'($urandom_range(7));
            cfg_div = ($urandom_range(19) == 0) ? 8'd255 : 8'($urandom_range(4));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
